mbist_march_ctrl: RTL and testbench
===================================

// Module: mbist_march_ctrl
// PURPOSE
//  March C- BIST engine that sits directly upstream of the single-bit test RAM (mbist_ram) and drives its cs/we/oe/addr/d_in.
//  It compares d_out against expected data and reports pass/fail and a failure count.
//  Algorithm: M0 {w0}, M1 up{r0,w1}, M2 up{r1,w0}, M3 down{r0,w1}, M4 down{r1,w0}, M5 {r0}. M0 and M5 run ascending.
// PARAMETERS
//  ADDR   8   RAM address width {row,col}; N = 2**ADDR cells
//  CNT_W  12  width of fail_cnt
// PORTS
//  clk       in   1       clock; all logic on posedge
//  rst       in   1       synchronous, active-high reset
//  start     in   1       1-cycle pulse; begins a test when in IDLE or DONE
//  ram_cs    out  1       RAM chip select
//  ram_we    out  1       RAM write enable
//  ram_oe    out  1       RAM read enable
//  ram_addr  out  ADDR    RAM address
//  ram_din   out  1       RAM write data
//  ram_dout  in   1       RAM read data (RAM registers it on negedge)
//  busy      out  1       test in progress
//  done      out  1       test finished; held until next start or rst
//  fail      out  1       sticky; at least one miscompare in current test
//  fail_cnt  out  CNT_W   number of miscompares; saturates at all-ones
// BEHAVIOUR
//  - Reset: every output is 0; FSM goes to IDLE; elem=0, op=0, addr counter=0. Reset mid-test aborts the test at that edge.
//  - All RAM-side outputs are registered. Exactly one RAM operation per clk cycle; no idle cycles between ops or elements.
//  - FSM states: IDLE -> (start) RUN -> (last op of M5 at last address) DONE -> (start) RUN. start is ignored while in RUN.
//  - On start: fail and fail_cnt clear; done clears; busy is 1 from the next cycle.
//  - Write cycle: cs=1, we=1, oe=0, din = the element's data value.
//  - Read cycle: cs=1, oe=1, we=0.
//  - Miscompare rule: ram_dout is compared with the expected value at the posedge that ends the read cycle (0 extra cycles).
//  - On a miscompare: fail <= 1 and fail_cnt increments on that same edge.
//  - Operation order: within an element, ops run in the listed order at one address, then the address steps.
//  - Address order: up elements go 0..N-1. Down elements go N-1..0.
//  - On element change: the address reloads (0 for up elements, N-1 for down elements). There is no wrap-around inside an element.
//  - Test length: exactly 10*N op cycles (2560 for ADDR=8).
//  - Completion: busy falls and done rises on the edge after the final M5 read has been compared.
//  - DONE outputs: cs/we/oe=0, ram_addr and ram_din=0.
//  - Saturation: fail_cnt holds at 2**CNT_W-1; fail stays 1.
// CONFIGURATION
//  - MBIST_DIAG_EN defined: extra outputs are added.
//      fail_addr[ADDR-1:0], fail_elem[2:0] and fail_exp capture the FIRST miscompare of the test.
//      They are cleared on rst and on start, and are frozen after the first capture.
//  - MBIST_DIAG_EN undefined: these ports and registers do not exist. Only fail/fail_cnt are reported.
// STRUCTURE
//  - Package mbist_pkg:
//      element index typedef (M0..M5);
//      op typedef {OP_R0, OP_R1, OP_W0, OP_W1};
//      March C- table: ops per element, op count and direction;
//      FSM state typedef {IDLE, RUN, DONE}.
//  - Sub-module mbist_addr_gen: loadable up/down counter with a first/last flag. Its inputs are load, dir and step.
//  - Top level holds the FSM, the element/op sequencing, the comparator and the counters.
// TESTING
//  1) Fault-free behavioural RAM, start pulse -> busy for 2560 cycles, then done=1, fail=0, fail_cnt=0.
//  2) mbist_ram with cfid_en=0 (SA0 at 8'h04) -> fail=1, fail_cnt=2.
//     Fails occur at M2 r1 and M4 r1, both at addr 8'h04.
//     With MBIST_DIAG_EN: fail_elem=2, fail_addr=8'h04, fail_exp=1.
//  3) Bench monitor on the RAM bus -> ops follow this cycle sequence:
//     M0 w0 @00..FF; M1 r0,w1 @00; M3 starts at addr FF; M5 r0 @FF is the last op.
//  4) rst asserted at cycle 1000 of a run -> all outputs 0 next edge.
//     A subsequent start reruns the full 2560 cycles with clean results.
//  5) start pulsed again mid-run -> ignored (cycle count is unchanged).
//     start pulsed in DONE -> results clear and the test reruns.
//  6) CNT_W=1 with a RAM stuck-at-0 everywhere -> fail_cnt saturates at 1 and fail=1.

Source files
------------

// File: rtl/mbist_pkg.sv
// mbist_pkg: March C- element/op table and FSM types shared by the BIST engine.
package mbist_pkg;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;
  typedef enum logic [1:0] {OP_R0, OP_R1, OP_W0, OP_W1} op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // op encoding: bit1 = write, bit0 = data value (written or expected)
  function automatic op_t march_op(elem_t e, logic i);
    return e == M0 ? OP_W0 :
           e == M5 ? OP_R0 :
           (e == M1 || e == M3) ? (i ? OP_W1 : OP_R0) : (i ? OP_W0 : OP_R1);
  endfunction
  function automatic logic [1:0] op_cnt(elem_t e);
    return (e == M0 || e == M5) ? 2'd1 : 2'd2;
  endfunction
  function automatic logic elem_down(elem_t e);
    return e == M3 || e == M4;
  endfunction
endpackage

// File: rtl/mbist_addr_gen.sv
// mbist_addr_gen: loadable up/down address counter with an end-of-sweep flag.
module mbist_addr_gen #(
  parameter int ADDR = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            dir_i,
  input  logic            step_i,
  output logic [ADDR-1:0] addr_o,
  output logic            last_o
);
  logic dir_q;
  // direction is latched at load so the flag never depends on the caller's next-state logic
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_o <= '0;
      dir_q  <= 1'b0;
    end else if (load_i) begin
      addr_o <= dir_i ? '1 : '0;
      dir_q  <= dir_i;
    end else if (step_i) begin
      addr_o <= dir_q ? addr_o - ADDR'(1) : addr_o + ADDR'(1);
    end
  end
  assign last_o = addr_o == (dir_q ? '0 : '1);
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST engine driving a 1-bit RAM; MBIST_DIAG_EN adds first-fail capture ports.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int ADDR  = 8,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ram_cs,
  output logic             ram_we,
  output logic             ram_oe,
  output logic [ADDR-1:0]  ram_addr,
  output logic             ram_din,
  input  logic             ram_dout,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] fail_cnt
`ifdef MBIST_DIAG_EN
  ,
  output logic [ADDR-1:0]  fail_addr,
  output logic [2:0]       fail_elem,
  output logic             fail_exp
`endif
);
  state_t state_q, state_d;
  elem_t  elem_q, elem_d;
  logic   op_q, op_d;
  logic   run, go, op_end, el_end, fin, mis, exp_bit, ld, dir, stp, a_last, run_d;
  op_t    nxt_op;
  mbist_addr_gen #(.ADDR(ADDR)) u_addr (
    .clk   (clk),
    .rst   (rst),
    .load_i(ld),
    .dir_i (dir),
    .step_i(stp),
    .addr_o(ram_addr),
    .last_o(a_last)
  );
  assign run     = state_q == RUN;
  assign go      = start && !run;
  assign op_end  = {1'b0, op_q} == op_cnt(elem_q) - 2'd1;
  assign el_end  = op_end && a_last;
  assign fin     = run && el_end && elem_q == M5;
  assign exp_bit = march_op(elem_q, op_q) == OP_R1;
  // the RAM presents read data on the negedge, so the read is checked at the edge closing its cycle
  assign mis     = ram_oe && ram_dout != exp_bit;
  always_comb begin
    state_d = go ? RUN : fin ? DONE : state_q;
    elem_d  = go ? M0 : (run && el_end && !fin) ? elem_t'(elem_q + 3'd1) : elem_q;
    op_d    = (go || (run && op_end)) ? 1'b0 : run ? 1'b1 : op_q;
    ld      = go || (run && el_end);
    dir     = elem_down(elem_d);
    stp     = run && op_end && !a_last;
    run_d   = state_d == RUN;
    nxt_op  = march_op(elem_d, op_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      elem_q   <= M0;
      op_q     <= 1'b0;
      ram_cs   <= 1'b0;
      ram_we   <= 1'b0;
      ram_oe   <= 1'b0;
      ram_din  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      fail_cnt <= '0;
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      op_q     <= op_d;
      ram_cs   <= run_d;
      ram_we   <= run_d && nxt_op[1];
      ram_oe   <= run_d && !nxt_op[1];
      ram_din  <= run_d && nxt_op[1] && nxt_op[0];
      busy     <= run_d;
      done     <= state_d == DONE;
      fail     <= go ? 1'b0 : fail || mis;
      fail_cnt <= go ? '0 : (mis && !(&fail_cnt)) ? fail_cnt + CNT_W'(1) : fail_cnt;
    end
  end
`ifdef MBIST_DIAG_EN
  always_ff @(posedge clk) begin
    if (rst || go) begin
      fail_addr <= '0;
      fail_elem <= '0;
      fail_exp  <= 1'b0;
    end else if (mis && !fail) begin
      fail_addr <= ram_addr;
      fail_elem <= elem_q;
      fail_exp  <= exp_bit;
    end
  end
`endif
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: random stuck-at faults vs. a March C- walk model; a CNT_W=1 twin sees an all-zero RAM.
module tb_mbist_march_ctrl;
  localparam int ADDR = 8;
  localparam int N = 1 << ADDR;
  localparam int LEN = 10 * N;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic cs, we, oe, din, dout = 1'b0, busy, done, fail;
  logic [ADDR-1:0] addr;
  logic [11:0] fcnt;
  logic cs1, we1, oe1, din1, busy1, done1, fail1, dout1;
  logic [ADDR-1:0] addr1;
  logic [0:0] fcnt1;
`ifdef MBIST_DIAG_EN
  logic [ADDR-1:0] faddr, faddr1;
  logic [2:0] felem, felem1;
  logic fexp, fexp1;
`endif
  int total = 0, bad = 0;
  assign dout1 = 1'b0;
  always #5 clk = ~clk;

  mbist_march_ctrl #(.ADDR(ADDR), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_cs(cs), .ram_we(we), .ram_oe(oe),
    .ram_addr(addr), .ram_din(din), .ram_dout(dout), .busy(busy), .done(done),
    .fail(fail), .fail_cnt(fcnt)
`ifdef MBIST_DIAG_EN
    , .fail_addr(faddr), .fail_elem(felem), .fail_exp(fexp)
`endif
  );
  mbist_march_ctrl #(.ADDR(ADDR), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .ram_cs(cs1), .ram_we(we1), .ram_oe(oe1),
    .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1), .busy(busy1), .done(done1),
    .fail(fail1), .fail_cnt(fcnt1)
`ifdef MBIST_DIAG_EN
    , .fail_addr(faddr1), .fail_elem(felem1), .fail_exp(fexp1)
`endif
  );

  bit sa0[N], sa1[N], mem[N];
  always @(negedge clk) begin
    if (cs && we) mem[addr] = din;
    if (cs && oe) dout <= sa0[addr] ? 1'b0 : sa1[addr] ? 1'b1 : mem[addr];
  end

  typedef struct packed {logic [2:0] e; logic wr; logic v; logic [ADDR-1:0] a;} op_s;
  op_s exp_q[$];
  int n_ops[6] = '{1, 2, 2, 2, 2, 1};
  bit down[6] = '{0, 0, 0, 1, 1, 0};
  bit is_wr[6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit dval[6][2]  = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  function automatic void build();
    exp_q.delete();
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < N; k++)
        for (int i = 0; i < n_ops[e]; i++)
          exp_q.push_back('{3'(e), is_wr[e][i], dval[e][i], ADDR'(down[e] ? N - 1 - k : k)});
  endfunction

  function automatic void model(input bit all0, output int cnt, output int fe, output int fa, output bit fx);
    bit mm[N];
    bit got;
    cnt = 0; fe = 0; fa = 0; fx = 0;
    foreach (exp_q[j]) begin
      if (exp_q[j].wr) mm[exp_q[j].a] = exp_q[j].v;
      else begin
        got = all0 ? 1'b0 : sa0[exp_q[j].a] ? 1'b0 : sa1[exp_q[j].a] ? 1'b1 : mm[exp_q[j].a];
        if (got != exp_q[j].v) begin
          if (cnt == 0) begin fe = exp_q[j].e; fa = exp_q[j].a; fx = exp_q[j].v; end
          cnt++;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < N; a++) begin sa0[a] = 0; sa1[a] = 0; end
  endtask

  task automatic rand_faults(input int nf);
    int a;
    clear_faults();
    for (int k = 0; k < nf; k++) begin
      a = $urandom_range(N - 1);
      if ($urandom_range(1) == 1) sa0[a] = 1; else sa1[a] = 1;
    end
  endtask

  task automatic do_run(input int restart_at);
    int cyc, seq_err, first_bad;
    op_s o;
    repeat ($urandom_range(4)) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("start_clears", {done, fail, fcnt}, 0);
    cyc = 0; seq_err = 0; first_bad = -1;
    while (busy && cyc < LEN + 20) begin
      start = (cyc == restart_at);
      o = exp_q[cyc % LEN];
      if ({cs, we, oe, addr} !== {1'b1, o.wr, ~o.wr, o.a} || (o.wr && din !== o.v)) begin
        if (seq_err == 0) first_bad = cyc;
        seq_err++;
      end
      cyc++;
      tick();
    end
    start = 1'b0;
    chk("bus_seq_errs", seq_err, 0);
    if (seq_err != 0) $display("first bus deviation at op %0d", first_bad);
    chk("busy_cycles", cyc, LEN);
    chk("done_set", {busy, done}, 2'b01);
    chk("done_bus_idle", {cs, we, oe, addr, din}, 0);
  endtask

  task automatic check_results(input string tag);
    int cnt, fe, fa;
    bit fx;
    model(1'b0, cnt, fe, fa, fx);
    chk({tag, "_fail"}, fail, cnt != 0);
    chk({tag, "_fail_cnt"}, fcnt, cnt > 4095 ? 4095 : cnt);
`ifdef MBIST_DIAG_EN
    chk({tag, "_diag"}, {faddr, felem, fexp}, {fa[ADDR-1:0], fe[2:0], fx});
`endif
    model(1'b1, cnt, fe, fa, fx);
    chk({tag, "_sat_cnt"}, {done1, fail1, fcnt1}, {1'b1, cnt != 0, cnt > 1 ? 1'b1 : cnt[0]});
  endtask

  initial begin
    build();
    clear_faults();
    repeat (3) tick();
    chk("reset_outs", {cs, we, oe, addr, din, busy, done, fail, fcnt}, 0);
    chk("reset_outs1", {cs1, we1, oe1, addr1, din1, busy1, done1, fail1, fcnt1}, 0);
    rst = 1'b0;
    tick();
    chk("idle_outs", {cs, we, oe, addr, din, busy, done, fail, fcnt}, 0);
    do_run(-1);
    check_results("clean");
    chk("clean_cnt_zero", fcnt, 0);
    sa0[4] = 1;
    do_run(-1);
    check_results("sa0_04");
    chk("sa0_04_cnt2", fcnt, 2);
`ifdef MBIST_DIAG_EN
    chk("sa0_04_first", {faddr, felem, fexp}, {8'h04, 3'd2, 1'b1});
`endif
    rand_faults(3);
    do_run(700);
    check_results("restart_ignored");
    rand_faults(5);
    do_run(-1);
    check_results("rerun_from_done");
    start = 1'b1; tick(); start = 1'b0;
    repeat (999) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_outs", {cs, we, oe, addr, din, busy, done, fail, fcnt}, 0);
    chk("abort_outs1", {cs1, we1, oe1, addr1, din1, busy1, done1, fail1, fcnt1}, 0);
    clear_faults();
    do_run(-1);
    check_results("after_abort");
    for (int r = 0; r < 2; r++) begin
      rand_faults($urandom_range(1, 8));
      do_run(-1);
      check_results("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
